// File: rtl/ga_pkg.sv
// Request/response types shared between ga_coprocessor and its clients.
package ga_pkg;

  localparam logic [3:0] GA_FUNCT_ADD     = 4'd0;
  localparam logic [3:0] GA_FUNCT_MUL     = 4'd1;
  localparam logic [3:0] GA_FUNCT_REFLECT = 4'd2;
  localparam logic [3:0] GA_FUNCT_ROTATE  = 4'd3;

  typedef struct packed {
    logic        valid;
    logic [3:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } ga_req_t;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic        error;
    logic [31:0] result;
  } ga_resp_t;

endpackage

// File: rtl/ga_coproc_arbiter.sv
// Round-robin arbiter sharing one ga_coprocessor among NUM_REQ requesters.
// Optional abort timer is built when GA_ARB_TIMEOUT_EN is defined.
module ga_coproc_arbiter
  import ga_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic     [NUM_REQ-1:0] req_valid_i,
  input  ga_req_t  [NUM_REQ-1:0] req_data_i,
  output logic     [NUM_REQ-1:0] req_ready_o,
  output logic     [NUM_REQ-1:0] resp_valid_o,
  output ga_resp_t              resp_data_o,
  output ga_req_t               ga_req_o,
  input  ga_resp_t              ga_resp_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     rr_ptr_q;
  logic [IdxW-1:0]     owner_q;
  logic                grant_vld;
  logic [IdxW-1:0]     grant_idx;
  logic [NUM_REQ-1:0]  owner_oh;
  ga_resp_t            err_resp;
  logic                abort;

  assign busy_o   = (state_q != StIdle);
  assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    err_resp       = '0;
    err_resp.error = 1'b1;
  end

  // First pending requester at or after rr_ptr_q, wrapping.
  always_comb begin
    int unsigned     k;
    logic [IdxW-1:0] idx;
    k         = 0;
    idx       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(rr_ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      idx = IdxW'(k);
      if (!grant_vld && req_valid_i[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

`ifdef GA_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            timeout_q;
  logic            in_flight;
  logic            expired;

  assign in_flight = (state_q == StIssue) || (state_q == StWait);
  assign expired   = in_flight && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  // A handshake arriving on the final cycle wins over the abort.
  assign abort     = expired && ((state_q == StIssue) ? !ga_resp_i.ready : !ga_resp_i.valid);
  assign timeout_o = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (in_flight && !(state_q == StIssue && ga_resp_i.ready)) cnt_q <= cnt_q + 1'b1;
      else                                                      cnt_q <= '0;
    end
  end
`else
  assign abort     = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      req_ready_o  <= '0;
      resp_valid_o <= '0;
      resp_data_o  <= '0;
      ga_req_o     <= '0;
    end else begin
      req_ready_o  <= '0;
      resp_valid_o <= '0;
      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            req_ready_o    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
            ga_req_o       <= req_data_i[grant_idx];
            ga_req_o.valid <= 1'b1;
            owner_q        <= grant_idx;
            rr_ptr_q       <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            state_q        <= StIssue;
          end
        end
        StIssue: begin
          if (ga_resp_i.ready) begin
            ga_req_o.valid <= 1'b0;
            if (ga_resp_i.valid) begin
              resp_data_o  <= ga_resp_i;
              resp_valid_o <= owner_oh;
              state_q      <= StResp;
            end else begin
              state_q <= StWait;
            end
          end else if (abort) begin
            ga_req_o.valid <= 1'b0;
            resp_data_o    <= err_resp;
            resp_valid_o   <= owner_oh;
            state_q        <= StResp;
          end
        end
        StWait: begin
          if (ga_resp_i.valid) begin
            resp_data_o  <= ga_resp_i;
            resp_valid_o <= owner_oh;
            state_q      <= StResp;
          end else if (abort) begin
            resp_data_o  <= err_resp;
            resp_valid_o <= owner_oh;
            state_q      <= StResp;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ga_coproc_arbiter.sv
// Scoreboard bench for ga_coproc_arbiter: random requesters and coprocessor model.
module tb_ga_coproc_arbiter;
  import ga_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned TO = 100;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic     [N-1:0]   req_valid;
  ga_req_t  [N-1:0]   req_data;
  logic     [N-1:0]   req_ready;
  logic     [N-1:0]   resp_valid;
  ga_resp_t           resp_data;
  ga_req_t            ga_req;
  ga_resp_t           ga_resp;
  logic               busy;
  logic               timeout;

  ga_coproc_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .resp_data_o  (resp_data),
    .ga_req_o     (ga_req),
    .ga_resp_i    (ga_resp),
    .busy_o       (busy),
    .timeout_o    (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passes = 0;
  int total  = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference behaviour of the coprocessor operation.
  function automatic logic [31:0] cp_func(input ga_req_t r);
    return (r.funct == GA_FUNCT_REFLECT) ? (r.op_a ^ r.op_b) : (r.op_a + r.op_b);
  endfunction

  // Round-robin rule: first pending requester at or after ptr.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++) if (v[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  typedef struct {
    int          owner;
    logic [31:0] result;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          grant_cyc[$];
  int          model_ptr  = 0;
  ga_req_t     exp_payload;
  int          resp_cnt[N];
  int          to_count   = 0;
  int          wait_entry = 0;
  logic [31:0] last_result;
  logic [N-1:0] prev_ready = '0;
  logic [N-1:0] prev_resp  = '0;
  bit          mon_en     = 1'b0;
  int          req_mode   = 1;  // 0 random, 1 directed, 2 always re-request
  int          cp_mode    = 1;  // 0 random, 1 result next cycle, 2 never, 3 same cycle

  // Monitor: compares DUT outputs against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (req_ready != '0) begin
        int           g;
        logic [N-1:0] oh;
        exp_t         e;
        g  = pick(req_valid, model_ptr);
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        check(g >= 0 && req_ready == oh && prev_ready == '0, "grant", req_ready, oh);
        if (g >= 0) begin
          model_ptr   = (g + 1) % N;
          exp_payload = req_data[g];
          e.owner     = g;
          e.err       = (cp_mode == 2);
          e.result    = e.err ? 32'h0 : cp_func(req_data[g]);
          sb.push_back(e);
          grant_log.push_back(g);
          grant_cyc.push_back(cyc);
        end
      end
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          check(1'b0, "spurious_resp", resp_valid, 0);
        end else begin
          exp_t         e;
          logic [N-1:0] oh;
          e  = sb.pop_front();
          oh = '0;
          oh[e.owner] = 1'b1;
          check(resp_valid == oh && prev_resp == '0, "resp_owner", resp_valid, oh);
          check(resp_data.result == e.result && resp_data.error == e.err, "resp_data",
                {resp_data.error, resp_data.result}, {e.err, e.result});
          resp_cnt[e.owner]++;
          last_result = resp_data.result;
        end
      end
      if (timeout) begin
        to_count++;
        check(cp_mode == 2 && cyc == wait_entry + TO && resp_valid != '0, "timeout_latency",
              cyc, wait_entry + TO);
      end
    end
    prev_ready = req_ready;
    prev_resp  = resp_valid;
  end

  bit          cp_busy  = 1'b0;
  int          cp_delay = 0;
  logic [31:0] cp_res;

  task automatic new_payload(input int i);
    req_data[i].valid = 1'b0;
    req_data[i].funct = 4'($urandom_range(0, 3));
    req_data[i].op_a  = $urandom;
    req_data[i].op_b  = $urandom;
  endtask

  // Coprocessor model and requester drivers, 1 unit after the falling edge.
  always @(negedge clk) begin
    #1;
    ga_resp = '0;
    if (!rst_n) begin
      cp_busy = 1'b0;
    end else begin
      if (cp_busy) begin
        if (cp_delay == 0) begin
          ga_resp.valid  = 1'b1;
          ga_resp.result = cp_res;
          cp_busy        = 1'b0;
        end else begin
          cp_delay--;
        end
      end else if (ga_req.valid) begin
        if (cp_mode != 0 || $urandom_range(0, 2) != 0) begin
          int d;
          check(ga_req.funct == exp_payload.funct && ga_req.op_a == exp_payload.op_a &&
                ga_req.op_b == exp_payload.op_b, "issue_payload", ga_req.op_a, exp_payload.op_a);
          ga_resp.ready = 1'b1;
          cp_res        = cp_func(ga_req);
          case (cp_mode)
            0:       d = $urandom_range(0, 3);
            1:       d = 1;
            3:       d = 0;
            default: d = -1;
          endcase
          if (d == 0) begin
            ga_resp.valid  = 1'b1;
            ga_resp.result = cp_res;
          end else if (d > 0) begin
            cp_busy  = 1'b1;
            cp_delay = d - 1;
          end else begin
            wait_entry = cyc + 1;
          end
        end
      end else if (cp_mode == 0 && $urandom_range(0, 7) == 0) begin
        ga_resp.valid  = 1'b1;
        ga_resp.result = $urandom;
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (req_mode == 2) new_payload(i);
          else               req_valid[i] = 1'b0;
        end else if (!req_valid[i] && req_mode == 0 && $urandom_range(0, 3) == 0) begin
          new_payload(i);
          req_valid[i] = 1'b1;
        end
      end
    end
  end

  task automatic post(input int i, input logic [3:0] f, input logic [31:0] a,
                      input logic [31:0] b);
    req_data[i].valid = 1'b0;
    req_data[i].funct = f;
    req_data[i].op_a  = a;
    req_data[i].op_b  = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy || req_valid != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check(1'b0, "wait_idle_budget", n, budget);
  endtask

  task automatic wait_grants(input int cnt, input int budget);
    int n = 0;
    while (grant_log.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check(1'b0, "wait_grants_budget", grant_log.size(), cnt);
  endtask

  initial begin
    int r0;
    int rnd_grants;
    req_valid = '0;
    req_data  = '0;
    ga_resp   = '0;
    for (int i = 0; i < N; i++) resp_cnt[i] = 0;

    repeat (3) @(negedge clk);
    check(req_ready == '0 && resp_valid == '0, "reset_pulses", {req_ready, resp_valid}, 0);
    check(!busy && !timeout, "reset_busy_timeout", {busy, timeout}, 0);
    check(ga_req == '0, "reset_ga_req", ga_req.op_a, 0);
    check(resp_data == '0, "reset_resp_data", resp_data.result, 0);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single request, reflect operation.
    @(negedge clk); #2;
    post(0, GA_FUNCT_REFLECT, 32'h1234_0000, 32'h0000_5678);
    wait_idle(50);
    check(last_result == 32'h1234_5678, "single_result", last_result, 32'h1234_5678);
    check(resp_cnt[0] == 1 && resp_cnt[1] == 0, "single_owner", resp_cnt[0], 1);

    // Reset while waiting on the coprocessor drops the transaction.
    @(negedge clk); #2;
    cp_mode = 2;
    post(0, GA_FUNCT_ADD, $urandom, $urandom);
    repeat (6) @(negedge clk);
    check(busy, "busy_in_wait", busy, 1);
    #2 rst_n = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    check(!busy && resp_valid == '0 && !timeout, "reset_in_wait", {busy, resp_valid, timeout}, 0);
    #2 rst_n = 1'b1;
    sb.delete();
    model_ptr = 0;
    mon_en    = 1'b1;
    cp_mode   = 1;
    r0        = resp_cnt[0];

    // Contention after reset: pointer restarts at requester 0.
    grant_log.delete();
    grant_cyc.delete();
    req_mode = 2;
    @(negedge clk); #2;
    post(0, GA_FUNCT_MUL, $urandom, $urandom);
    post(1, GA_FUNCT_ADD, $urandom, $urandom);
    wait_grants(4, 60);
    req_mode = 1;
    wait_idle(60);
    if (grant_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check(grant_log[i] == i % 2, "contention_order", grant_log[i], i % 2);
      check(grant_cyc[1] - grant_cyc[0] == 4, "throughput_4", grant_cyc[1] - grant_cyc[0], 4);
    end
    check(resp_cnt[0] - r0 >= 2, "no_resp_after_reset_drop", resp_cnt[0] - r0, 2);

    // Coprocessor answers in the issue cycle: issue jumps straight to response.
    cp_mode = 3;
    grant_log.delete();
    grant_cyc.delete();
    req_mode = 2;
    @(negedge clk); #2;
    post(0, GA_FUNCT_ROTATE, $urandom, $urandom);
    post(1, GA_FUNCT_REFLECT, $urandom, $urandom);
    wait_grants(3, 60);
    req_mode = 1;
    wait_idle(60);
    if (grant_cyc.size() >= 2)
      check(grant_cyc[1] - grant_cyc[0] == 3, "issue_direct_resp", grant_cyc[1] - grant_cyc[0], 3);

    // Requester 1 alone.
    cp_mode = 1;
    r0 = resp_cnt[1];
    @(negedge clk); #2;
    post(1, GA_FUNCT_ADD, 32'h10, 32'h20);
    wait_idle(50);
    check(resp_cnt[1] == r0 + 1 && last_result == 32'h30, "req1_alone", last_result, 32'h30);

    // Random traffic with spurious coprocessor responses while idle.
    cp_mode  = 0;
    req_mode = 0;
    rnd_grants = grant_log.size();
    repeat (3000) @(negedge clk);
    req_mode = 1;
    wait_idle(200);
    check(grant_log.size() - rnd_grants >= 100, "random_progress", grant_log.size() - rnd_grants, 100);

`ifdef GA_ARB_TIMEOUT_EN
    cp_mode = 2;
    @(negedge clk); #2;
    post(1, GA_FUNCT_MUL, $urandom, $urandom);
    wait_idle(TO + 50);
    check(to_count == 1, "timeout_count", to_count, 1);
`else
    check(to_count == 0, "timeout_tied_low", to_count, 0);
`endif
    check(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
